// File: rtl/i2c_target_rx.sv
// I2C target receiver: oversamples scl/sda, detects START/Sr/STOP, ACKs a
// matching write address and strobes out each received data byte.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR        = 7'h2A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       addressed,
  output logic [7:0] byte_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;

  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start;
  logic                   w_stop;
  logic [7:0]             w_shifted;

  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [7:0]             r_dout;
  logic                   r_rx_valid;
  logic                   r_start_det;
  logic                   r_stop_det;
  logic                   r_addressed;
  logic [7:0]             r_byte_count;
  logic                   r_sda_oe;
  logic                   r_ack_half;

  state_t                 w_state_nxt;
  logic [2:0]             w_bit_cnt_nxt;
  logic [7:0]             w_shift_nxt;
  logic [7:0]             w_dout_nxt;
  logic                   w_rx_valid_nxt;
  logic                   w_start_det_nxt;
  logic                   w_stop_det_nxt;
  logic                   w_addressed_nxt;
  logic [7:0]             w_byte_count_nxt;
  logic                   w_sda_oe_nxt;
  logic                   w_ack_half_nxt;

  // Synchronisers reset high so an idle bus is not mistaken for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_q    <= w_scl_s;
      r_sda_q    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_q;
  assign w_scl_fall = ~w_scl_s & r_scl_q;
  // Requiring scl steady high suppresses START/STOP when scl and sda move together.
  assign w_start    = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
  assign w_shifted  = {r_shift[6:0], w_sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_rx_valid   <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_addressed  <= 1'b0;
      r_byte_count <= '0;
      r_sda_oe     <= 1'b0;
      r_ack_half   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_dout       <= w_dout_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_start_det  <= w_start_det_nxt;
      r_stop_det   <= w_stop_det_nxt;
      r_addressed  <= w_addressed_nxt;
      r_byte_count <= w_byte_count_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_ack_half   <= w_ack_half_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_dout_nxt       = r_dout;
    w_rx_valid_nxt   = 1'b0;
    w_start_det_nxt  = 1'b0;
    w_stop_det_nxt   = 1'b0;
    w_addressed_nxt  = r_addressed;
    w_byte_count_nxt = r_byte_count;
    w_sda_oe_nxt     = r_sda_oe;
    w_ack_half_nxt   = r_ack_half;

    if (w_start) begin
      w_state_nxt      = S_ADDR;
      w_bit_cnt_nxt    = '0;
      w_shift_nxt      = '0;
      w_byte_count_nxt = '0;
      w_addressed_nxt  = 1'b0;
      w_sda_oe_nxt     = 1'b0;
      w_ack_half_nxt   = 1'b0;
      w_start_det_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_bit_cnt_nxt   = '0;
      w_shift_nxt     = '0;
      w_addressed_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
      w_ack_half_nxt  = 1'b0;
      w_stop_det_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_shifted;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt = '0;
              if (w_shifted[7:1] == ADDR && !w_shifted[0]) w_state_nxt = S_ADDR_ACK;
              else                                          w_state_nxt = S_IGNORE;
            end
          end
        end
        // First falling edge ends the 8th bit (drive ACK); second ends the 9th (release).
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_half) begin
              w_sda_oe_nxt    = 1'b1;
              w_addressed_nxt = 1'b1;
              w_ack_half_nxt  = 1'b1;
            end else begin
              w_sda_oe_nxt   = 1'b0;
              w_ack_half_nxt = 1'b0;
              w_state_nxt    = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_shifted;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt  = '0;
              w_dout_nxt     = w_shifted;
              w_rx_valid_nxt = 1'b1;
              if (r_byte_count != 8'hFF) w_byte_count_nxt = r_byte_count + 8'd1;
              w_state_nxt    = S_DATA_ACK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe     = r_sda_oe;
  assign dout       = r_dout;
  assign rx_valid   = r_rx_valid;
  assign start_det  = r_start_det;
  assign stop_det   = r_stop_det;
  assign addressed  = r_addressed;
  assign byte_count = r_byte_count;
  assign busy       = (r_state != S_IDLE);

endmodule
